branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch/jump resolution stage that sits directly upstream of the program counter. It decodes the current 9-bit instruction, holds the ALU zero flag and a loadable 16-entry branch-target lookup table, and drives Target/beq_flag/jmp_flag into the PC. It also owns the run/halt state machine: it suppresses branches during start-up and freezes the PC once a HALT retires.

## Interface
Parameters:
- A, 10, PC/target address width.
- LUT_N, 16, branch-target LUT depth; index width is $clog2(LUT_N) = 4.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- Reset, input, 1, synchronous, active-high reset.
- Instr, input, 9, instruction currently addressed by the PC (combinational ROM output).
- ProgCtr, input, A, current PC value; used as the hold target in HALT.
- AluZero, input, 1, ALU zero result for the current instruction.
- AluFlagWe, input, 1, loads AluZero into the Z flag register.
- LutWe, input, 1, LUT write enable.
- LutAddr, input, 4, LUT write index.
- LutData, input, A, LUT write data.
- Target, output, A, jump/branch destination to the PC.
- beq_flag, output, 1, taken conditional branch.
- jmp_flag, output, 1, unconditional jump or HALT hold.
- Done, output, 1, high while in HALT.
- TakenCount, output, 16, count of taken beq/jmp, excluding HALT holds.

## Operation
- Opcode is Instr[8:5] and the LUT index is Instr[3:0].
- Opcode encodings:
  - BEQ = 4'b1110.
  - JMP = 4'b1111.
  - HALT = 4'b1101.
  - All other opcodes are non-control and produce no flags.
- FSM states are IDLE, RUN and HALT.
  - Reset forces IDLE.
  - IDLE goes to RUN on the first cycle where Reset is low. This gives one dead cycle, matching the PC start-up.
  - RUN goes to HALT on the edge where Instr is HALT.
  - HALT is left only by Reset.
- In IDLE, all flags are 0, Target is 0 and Done is 0.
- In RUN, outputs are combinational from Instr and the registered Z:
  - JMP: jmp_flag=1, Target=LUT[idx].
  - BEQ: beq_flag=Z, Target=LUT[idx]. Target is driven with LUT[idx] even when Z=0.
  - Otherwise: both flags 0, Target=0.
  - A HALT instruction in RUN asserts no flags in that cycle. The PC therefore advances once more.
- In HALT, jmp_flag=1, beq_flag=0, Target=ProgCtr and Done=1. The PC holds its value indefinitely.
- Z register:
  - Resets to 0.
  - Loads AluZero on an edge where AluFlagWe=1, in any state.
  - A BEQ evaluated in the same cycle as AluFlagWe uses the old Z.
- LUT:
  - LUT_N x A registers, all reset to 0.
  - A write on LutWe takes effect at the edge. A same-cycle read of the same index returns the old value.
  - Writes are accepted in every state.
- TakenCount:
  - Resets to 0.
  - Increments on each edge in RUN where beq_flag or jmp_flag is 1.
  - Saturates at 16'hFFFF.

## Timing
- Decision latency is 0 cycles: the flags and Target are valid in the same cycle as Instr, and the PC consumes them at the next edge.
- Z, the LUT, the FSM and TakenCount are updated at posedge and become visible the cycle after the qualifying input.
- Reset mid-operation: on the next edge the state is IDLE and the LUT, Z and TakenCount are cleared. The outputs go to their reset values combinationally from the registered state in the cycle after that edge.
- Reset values of all outputs: Target=0, beq_flag=0, jmp_flag=0, Done=0, TakenCount=0.
- Simultaneous LutWe and a branch on the same index: the branch uses the old entry.

## Structure
- The shared package holds:
  - the opcode constants OP_BEQ, OP_JMP, OP_HALT;
  - the state enum type state_t {IDLE, RUN, HALT};
  - the LUT_N constant.
- One sub-module is natural: branch_lut, the register file with a reset-cleared write port and an async read port.
- Everything else (FSM, Z register, decode, counter) lives in branch_ctrl.

## Test plan
- Reset start-up: hold Reset for 2 cycles, then release with Instr=JMP idx 0. Cycle 1 after release: jmp_flag=0 (IDLE). Cycle 2: jmp_flag=1, Target=0.
- LUT write then jump: write LUT[5]=10'h123, then Instr=JMP idx 5. Required: jmp_flag=1, Target=10'h123, TakenCount=1 after the edge. A same-cycle write of LUT[5] must still show the old value.
- BEQ with flag:
  - Apply AluFlagWe=1 with AluZero=1, then BEQ idx 3 with LUT[3]=10'h040. Required: beq_flag=1, Target=10'h040.
  - Repeat after loading Z=0. Required: beq_flag=0 and TakenCount unchanged.
- Same-cycle flag write: with Z=0, apply BEQ together with AluFlagWe=1 and AluZero=1. Required: beq_flag=0 in that cycle.
- HALT: apply Instr=HALT at ProgCtr=10'h07F.
  - In that cycle: no flags.
  - After the edge: Done=1, jmp_flag=1, Target=ProgCtr, held for 20 cycles.
  - TakenCount stays frozen.
  - Reset must return the block to IDLE with Done=0.
- Saturation: force 70000 taken JMPs. Required: TakenCount=16'hFFFF and no wrap.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch/jump resolution stage.
package branch_ctrl_pkg;

    localparam int LUT_N = 16;

    localparam logic [3:0] OP_BEQ  = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;
    localparam logic [3:0] OP_HALT = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_ctrl_lut.sv
// Branch-target table: reset-cleared registers, one write port, one async read port.
module branch_lut #(
    parameter int A = 10,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [A-1:0]         wdata,
    input  logic [$clog2(N)-1:0] raddr,
    output logic [A-1:0]         rdata
);

    logic [A-1:0] mem_r [N];

    // Table storage; reads see the pre-edge contents on a same-index write.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution and run/halt control feeding the program counter.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int A     = 10,
    parameter int LUT_N = 16
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic [8:0]               Instr,
    input  logic [A-1:0]             ProgCtr,
    input  logic                     AluZero,
    input  logic                     AluFlagWe,
    input  logic                     LutWe,
    input  logic [$clog2(LUT_N)-1:0] LutAddr,
    input  logic [A-1:0]             LutData,
    output logic [A-1:0]             Target,
    output logic                     beq_flag,
    output logic                     jmp_flag,
    output logic                     Done,
    output logic [15:0]              TakenCount
);

    localparam int IW = $clog2(LUT_N);

    state_t          state_r;
    state_t          state_nxt_s;
    logic            z_r;
    logic [15:0]     count_r;
    logic [3:0]      opcode_s;
    logic [IW-1:0]   idx_s;
    logic [A-1:0]    lut_rd_s;
    logic            taken_s;
    logic            unused_s;

    assign opcode_s = Instr[8:5];
    assign idx_s    = Instr[IW-1:0];
    assign unused_s = Instr[4];

    branch_lut #(
        .A (A),
        .N (LUT_N)
    ) u_lut (
        .clk   (clk),
        .Reset (Reset),
        .we    (LutWe),
        .waddr (LutAddr),
        .wdata (LutData),
        .raddr (idx_s),
        .rdata (lut_rd_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: one dead cycle in IDLE, HALT is sticky until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = RUN;
            RUN: begin
                if (opcode_s == OP_HALT) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT:    state_nxt_s = HALT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; zero-latency so the PC can consume it at the next edge.
    always_comb begin
        Target   = '0;
        beq_flag = 1'b0;
        jmp_flag = 1'b0;
        Done     = 1'b0;
        case (state_r)
            RUN: begin
                case (opcode_s)
                    OP_JMP: begin
                        jmp_flag = 1'b1;
                        Target   = lut_rd_s;
                    end
                    OP_BEQ: begin
                        beq_flag = z_r;
                        Target   = lut_rd_s;
                    end
                    default: begin
                        Target = '0;
                    end
                endcase
            end
            HALT: begin
                jmp_flag = 1'b1;
                Target   = ProgCtr;
                Done     = 1'b1;
            end
            default: begin
                Target = '0;
            end
        endcase
    end

    // HALT holds also raise jmp_flag, so only RUN-state decisions are counted.
    assign taken_s = (state_r == RUN) && (beq_flag || jmp_flag);

    // Zero flag register; a same-cycle BEQ sees the previous value.
    always_ff @(posedge clk) begin
        if (Reset) begin
            z_r <= 1'b0;
        end else if (AluFlagWe) begin
            z_r <= AluZero;
        end else begin
            z_r <= z_r;
        end
    end

    // Saturating taken-branch counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            count_r <= 16'd0;
        end else if (taken_s && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign TakenCount = count_r;

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized self-checking bench for branch_ctrl against a behavioural model.
module tb_branch_ctrl;

    logic        clk;
    logic        Reset;
    logic [8:0]  Instr;
    logic [9:0]  ProgCtr;
    logic        AluZero;
    logic        AluFlagWe;
    logic        LutWe;
    logic [3:0]  LutAddr;
    logic [9:0]  LutData;
    logic [9:0]  Target;
    logic        beq_flag;
    logic        jmp_flag;
    logic        Done;
    logic [15:0] TakenCount;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [9:0] m_lut [16];
    logic       m_z;
    logic       m_started;
    logic       m_halted;
    int         m_count;

    logic [28:0] exp_v;
    logic [28:0] got_v;

    branch_ctrl #(.A(10), .LUT_N(16)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Instr      (Instr),
        .ProgCtr    (ProgCtr),
        .AluZero    (AluZero),
        .AluFlagWe  (AluFlagWe),
        .LutWe      (LutWe),
        .LutAddr    (LutAddr),
        .LutData    (LutData),
        .Target     (Target),
        .beq_flag   (beq_flag),
        .jmp_flag   (jmp_flag),
        .Done       (Done),
        .TakenCount (TakenCount)
    );

    always #5 clk = ~clk;

    assign got_v = {Target, beq_flag, jmp_flag, Done, TakenCount};

    // Expected outputs {Target, beq, jmp, Done, TakenCount} for the current inputs.
    function automatic logic [28:0] model_out();
        logic [9:0] t;
        logic       b;
        logic       j;
        logic       d;
        t = 10'd0; b = 1'b0; j = 1'b0; d = 1'b0;
        if (m_halted) begin
            t = ProgCtr; j = 1'b1; d = 1'b1;
        end else if (m_started) begin
            if (Instr[8:5] == 4'b1111) begin
                j = 1'b1; t = m_lut[Instr[3:0]];
            end else if (Instr[8:5] == 4'b1110) begin
                b = m_z;  t = m_lut[Instr[3:0]];
            end
        end
        return {t, b, j, d, m_count[15:0]};
    endfunction

    // Advance one clock and apply the rules to the model; returns at the negedge.
    task automatic tick();
        logic [28:0] e;
        e = model_out();
        @(posedge clk);
        if (Reset) begin
            for (int i = 0; i < 16; i++) m_lut[i] = 10'd0;
            m_z = 1'b0; m_started = 1'b0; m_halted = 1'b0; m_count = 0;
        end else begin
            if (m_started && !m_halted && (e[18] || e[17]) && m_count < 65535)
                m_count = m_count + 1;
            if (m_started && !m_halted && Instr[8:5] == 4'b1101)
                m_halted = 1'b1;
            m_started = 1'b1;
            if (AluFlagWe) m_z = AluZero;
            if (LutWe) m_lut[LutAddr] = LutData;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        Reset = 1'b0; Instr = 9'h000; ProgCtr = 10'h000; AluZero = 1'b0;
        AluFlagWe = 1'b0; LutWe = 1'b0; LutAddr = 4'h0; LutData = 10'h000;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        #1;
        exp_v = model_out(); checks++;
        if (got_v !== exp_v || got_v !== 29'd0) begin
            errors++; $display("FAIL reset_hold: got %h exp %h", got_v, 29'd0);
        end
        tick();
        Reset = 1'b0; Instr = {4'b1111, 1'b0, 4'h0};
        #1;
        exp_v = model_out(); checks++;
        if (jmp_flag !== 1'b0 || got_v !== exp_v) begin
            errors++; $display("FAIL reset_dead_cycle: got %h exp %h", got_v, exp_v);
        end
        tick();
        #1;
        exp_v = model_out(); checks++;
        if (jmp_flag !== 1'b1 || Target !== 10'h000 || got_v !== exp_v) begin
            errors++; $display("FAIL reset_first_jmp: got %h exp %h", got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_lut_jump();
        idle_inputs();
        LutWe = 1'b1; LutAddr = 4'd5; LutData = 10'h123;
        tick();
        Instr = {4'b1111, 1'b0, 4'd5}; LutWe = 1'b1; LutAddr = 4'd5; LutData = 10'h2AA;
        #1;
        exp_v = model_out(); checks++;
        if (Target !== 10'h123 || jmp_flag !== 1'b1 || got_v !== exp_v) begin
            errors++; $display("FAIL lut_jump_old: got %h exp %h", got_v, exp_v);
        end
        tick();
        LutWe = 1'b0;
        #1;
        exp_v = model_out(); checks++;
        if (Target !== 10'h2AA || got_v !== exp_v) begin
            errors++; $display("FAIL lut_jump_new: got %h exp %h", got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_beq();
        idle_inputs();
        LutWe = 1'b1; LutAddr = 4'd3; LutData = 10'h040; AluFlagWe = 1'b1; AluZero = 1'b1;
        tick();
        idle_inputs();
        Instr = {4'b1110, 1'b0, 4'd3};
        #1;
        exp_v = model_out(); checks++;
        if (beq_flag !== 1'b1 || Target !== 10'h040 || got_v !== exp_v) begin
            errors++; $display("FAIL beq_taken: got %h exp %h", got_v, exp_v);
        end
        tick();
        Instr = 9'h000; AluFlagWe = 1'b1; AluZero = 1'b0;
        tick();
        AluFlagWe = 1'b0; Instr = {4'b1110, 1'b0, 4'd3};
        #1;
        exp_v = model_out(); checks++;
        if (beq_flag !== 1'b0 || Target !== 10'h040 || got_v !== exp_v) begin
            errors++; $display("FAIL beq_not_taken: got %h exp %h", got_v, exp_v);
        end
        tick();
        AluFlagWe = 1'b1; AluZero = 1'b1;
        #1;
        exp_v = model_out(); checks++;
        if (beq_flag !== 1'b0 || got_v !== exp_v) begin
            errors++; $display("FAIL beq_same_cycle_z: got %h exp %h", got_v, exp_v);
        end
        tick();
        AluFlagWe = 1'b0;
        #1;
        exp_v = model_out(); checks++;
        if (beq_flag !== 1'b1 || got_v !== exp_v) begin
            errors++; $display("FAIL beq_after_z: got %h exp %h", got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b1101) op = 4'b0000;
            if ($urandom_range(0, 2) == 0) op = 4'b1110 | 4'($urandom_range(0, 1));
            Instr     = {op, 1'($urandom), 4'($urandom)};
            ProgCtr   = 10'($urandom);
            AluZero   = 1'($urandom);
            AluFlagWe = 1'($urandom);
            LutWe     = 1'($urandom);
            LutAddr   = 4'($urandom);
            LutData   = 10'($urandom);
            Reset     = ($urandom_range(0, 60) == 0);
            #1;
            exp_v = model_out(); checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random[%0d]: got %h exp %h", n, got_v, exp_v);
            end
            tick();
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        logic [15:0] frozen;
        idle_inputs();
        ProgCtr = 10'h07F; Instr = {4'b1101, 1'b0, 4'h0};
        #1;
        exp_v = model_out(); checks++;
        if (jmp_flag !== 1'b0 || beq_flag !== 1'b0 || Done !== 1'b0 || got_v !== exp_v) begin
            errors++; $display("FAIL halt_issue: got %h exp %h", got_v, exp_v);
        end
        frozen = TakenCount;
        tick();
        for (int n = 0; n < 20; n++) begin
            Instr = {4'b111, 1'($urandom), 1'b0, 4'($urandom)};
            AluFlagWe = 1'($urandom); AluZero = 1'b1;
            #1;
            exp_v = model_out(); checks++;
            if (Done !== 1'b1 || jmp_flag !== 1'b1 || Target !== 10'h07F ||
                TakenCount !== frozen || got_v !== exp_v) begin
                errors++; $display("FAIL halt_hold[%0d]: got %h exp %h", n, got_v, exp_v);
            end
            tick();
        end
        idle_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        exp_v = model_out(); checks++;
        if (Done !== 1'b0 || jmp_flag !== 1'b0 || TakenCount !== 16'd0 || got_v !== exp_v) begin
            errors++; $display("FAIL halt_reset: got %h exp %h", got_v, exp_v);
        end
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        Instr = {4'b1111, 1'b0, 4'h2};
        for (int n = 0; n < 70000; n++) begin
            if ((n % 8192) == 0) begin
                #1;
                exp_v = model_out(); checks++;
                if (got_v !== exp_v) begin
                    errors++; $display("FAIL sat_progress[%0d]: got %h exp %h", n, got_v, exp_v);
                end
            end
            tick();
        end
        #1;
        exp_v = model_out(); checks++;
        if (TakenCount !== 16'hFFFF || got_v !== exp_v) begin
            errors++; $display("FAIL sat_final: got %h exp %h", TakenCount, 16'hFFFF);
        end
    endtask

    initial begin
        clk = 1'b0;
        idle_inputs();
        for (int i = 0; i < 16; i++) m_lut[i] = 10'd0;
        m_z = 1'b0; m_started = 1'b0; m_halted = 1'b0; m_count = 0;
        test_reset();
        test_lut_jump();
        test_beq();
        test_random();
        test_halt();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
